// File: rtl/line_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types, width defaults and tie-break function for line_mem_arbiter
package mem_arb_pkg;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [LINE_W_DEF-1:0] wdata;
    logic                  is_write;
  } line_req_t;
  function automatic req_id_t pick_grant(input logic i_pend, input logic d_pend, input req_id_t last, input logic d_prio);
    return !i_pend ? REQ_D : !d_pend ? REQ_I : d_prio ? REQ_D : (last == REQ_I ? REQ_D : REQ_I);
  endfunction
endpackage

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one cacheline memory port between I-cache and D-cache, round-robin or D-priority
module line_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter bit          D_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       grant_cnt_i,
  output logic [31:0]       grant_cnt_d
);
  arb_state_t        state_q, state_d;
  req_id_t           last_q, last_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [31:0]       cnt_i_q, cnt_i_d, cnt_d_q, cnt_d_d;
  logic              i_pend, d_pend, grant, serving;
  always_comb begin
    i_pend = i_read | i_write;
    d_pend = d_read | d_write;
    pick = pick_grant(i_pend, d_pend, last_q, D_PRIO);
    grant = state_q == IDLE && (i_pend || d_pend);
    serving = state_q != IDLE;
    state_d = grant ? (pick == REQ_D ? SERVE_D : SERVE_I) : (serving && mem_resp ? IDLE : state_q);
    last_d = grant ? pick : last_q;
    addr_d = grant ? (pick == REQ_D ? d_addr : i_addr) : addr_q;
    wdata_d = grant ? (pick == REQ_D ? d_wdata : i_wdata) : wdata_q;
    wr_d = grant ? (pick == REQ_D ? d_write : i_write) : wr_q;
    cnt_i_d = cnt_i_q + 32'(grant && pick == REQ_I);
    cnt_d_d = cnt_d_q + 32'(grant && pick == REQ_D);
    mem_read = serving && !wr_q;
    mem_write = serving && wr_q;
    mem_addr = serving ? addr_q : '0;
    mem_wdata = serving ? wdata_q : '0;
    i_resp = state_q == SERVE_I && mem_resp;
    d_resp = state_q == SERVE_D && mem_resp;
    i_rdata = i_resp && !wr_q ? mem_rdata : '0;
    d_rdata = d_resp && !wr_q ? mem_rdata : '0;
    grant_cnt_i = cnt_i_q;
    grant_cnt_d = cnt_d_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= REQ_I;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      cnt_i_q <= '0;
      cnt_d_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
    end
  end
  a_i_rw: assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
  a_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
  a_idle_resp: assert property (@(posedge clk) disable iff (rst) !(state_q == IDLE && mem_resp));
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: self-checking bench for line_mem_arbiter, round-robin and D-priority instances
module tb_line_mem_arbiter;
  logic         clk, rst;
  logic [31:0]  i_addr[2], d_addr[2], mem_addr[2], gci[2], gcd[2];
  logic         i_read[2], i_write[2], i_resp[2], d_read[2], d_write[2], d_resp[2];
  logic         mem_read[2], mem_write[2], mem_resp[2];
  logic [255:0] i_wdata[2], i_rdata[2], d_wdata[2], d_rdata[2], mem_wdata[2], mem_rdata[2];
  logic [255:0] store [logic [32:0]];
  int           age[2], lat[2];
  bit           rnd_lat;
  int           errs, checks;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    line_mem_arbiter #(.D_PRIO(g == 1)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr[g]), .i_read(i_read[g]), .i_write(i_write[g]), .i_wdata(i_wdata[g]),
      .i_rdata(i_rdata[g]), .i_resp(i_resp[g]),
      .d_addr(d_addr[g]), .d_read(d_read[g]), .d_write(d_write[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_resp(d_resp[g]),
      .mem_addr(mem_addr[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_resp(mem_resp[g]),
      .grant_cnt_i(gci[g]), .grant_cnt_d(gcd[g])
    );
  end
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [255:0] dflt(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = {8{$urandom}};
      if (rst || !(mem_read[k] || mem_write[k])) begin
        mem_resp[k] = 0;
        age[k] = 0;
      end else begin
        if (age[k] == 0 && rnd_lat) lat[k] = $urandom_range(0, 3);
        mem_resp[k] = age[k] == lat[k];
        if (mem_resp[k]) begin
          if (mem_write[k]) store[{k[0], mem_addr[k]}] = mem_wdata[k];
          else mem_rdata[k] = store.exists({k[0], mem_addr[k]}) ? store[{k[0], mem_addr[k]}] : dflt(mem_addr[k]);
        end
        age[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (i_resp[k]) begin i_read[k] = 0; i_write[k] = 0; end
      if (d_resp[k]) begin d_read[k] = 0; d_write[k] = 0; end
    end
  endtask
  task automatic do_reset();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0; i_write[k] = 0; d_read[k] = 0; d_write[k] = 0;
      i_addr[k] = 0; d_addr[k] = 0; i_wdata[k] = 0; d_wdata[k] = 0;
    end
    tick();
    tick();
    rst = 0;
    store.delete();
  endtask
  task automatic test_reset();
    do_reset();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({mem_read[k], mem_write[k], i_resp[k], d_resp[k]} !== 4'b0) begin
        errs++; $display("FAIL reset_ctl[%0d]: got %b want 0000", k, {mem_read[k], mem_write[k], i_resp[k], d_resp[k]});
      end
      checks++;
      if (mem_addr[k] !== 32'h0 || mem_wdata[k] !== 256'h0) begin
        errs++; $display("FAIL reset_mem[%0d]: addr %0h wdata %0h want 0", k, mem_addr[k], mem_wdata[k]);
      end
      checks++;
      if (i_rdata[k] !== 256'h0 || d_rdata[k] !== 256'h0) begin
        errs++; $display("FAIL reset_rdata[%0d]: i %0h d %0h want 0", k, i_rdata[k], d_rdata[k]);
      end
      checks++;
      if (gci[k] !== 32'h0 || gcd[k] !== 32'h0) begin
        errs++; $display("FAIL reset_cnt[%0d]: i %0d d %0d want 0", k, gci[k], gcd[k]);
      end
    end
  endtask
  task automatic test_i_read();
    do_reset();
    rnd_lat = 0;
    lat[0] = 5;
    store[{1'b0, 32'h1000}] = {32{8'hA5}};
    i_addr[0] = 32'h1000;
    i_read[0] = 1;
    tick();
    checks++;
    if (mem_read[0] !== 1'b1 || mem_write[0] !== 1'b0 || mem_addr[0] !== 32'h1000) begin
      errs++; $display("FAIL iread_cmd: rd %b wr %b addr %0h want 1 0 1000", mem_read[0], mem_write[0], mem_addr[0]);
    end
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (i_resp[0] !== (n == 5)) begin
        errs++; $display("FAIL iread_resp_n%0d: got %b want %b", n, i_resp[0], n == 5);
      end
    end
    checks++;
    if (i_rdata[0] !== {32{8'hA5}}) begin
      errs++; $display("FAIL iread_rdata: got %0h want %0h", i_rdata[0], {32{8'hA5}});
    end
    checks++;
    if (d_resp[0] !== 1'b0 || d_rdata[0] !== 256'h0) begin
      errs++; $display("FAIL iread_dside: resp %b rdata %0h want 0", d_resp[0], d_rdata[0]);
    end
    tick();
    checks++;
    if (mem_read[0] !== 1'b0 || gci[0] !== 32'd1 || gcd[0] !== 32'd0) begin
      errs++; $display("FAIL iread_after: rd %b cnt_i %0d cnt_d %0d want 0 1 0", mem_read[0], gci[0], gcd[0]);
    end
  endtask
  task automatic test_tie();
    logic [31:0] starts[$];
    int          scyc[$];
    int          respd, n;
    bit          prev, done;
    do_reset();
    rnd_lat = 0;
    lat[0] = 2;
    i_addr[0] = 32'h100; i_read[0] = 1;
    d_addr[0] = 32'h200; d_read[0] = 1;
    prev = 0; done = 0; respd = -100;
    for (n = 0; n < 40 && !done; n++) begin
      tick();
      if (mem_read[0] && !prev) begin starts.push_back(mem_addr[0]); scyc.push_back(n); end
      prev = mem_read[0];
      if (d_resp[0]) begin
        respd = n;
        checks++;
        if (d_rdata[0] !== dflt(32'h200)) begin
          errs++; $display("FAIL tie_d_rdata: got %0h want %0h", d_rdata[0], dflt(32'h200));
        end
      end
      if (i_resp[0]) begin
        done = 1;
        checks++;
        if (i_rdata[0] !== dflt(32'h100)) begin
          errs++; $display("FAIL tie_i_rdata: got %0h want %0h", i_rdata[0], dflt(32'h100));
        end
      end
    end
    checks++;
    if (!done || starts.size() != 2) begin
      errs++; $display("FAIL tie_count: done %b starts %0d want 1 2", done, starts.size());
    end else begin
      checks++;
      if (starts[0] !== 32'h200 || starts[1] !== 32'h100) begin
        errs++; $display("FAIL tie_order: got %0h,%0h want 200,100", starts[0], starts[1]);
      end
      checks++;
      if (scyc[1] - respd != 2) begin
        errs++; $display("FAIL tie_gap: got %0d want 2", scyc[1] - respd);
      end
    end
    tick();
    checks++;
    if (gci[0] !== 32'd1 || gcd[0] !== 32'd1) begin
      errs++; $display("FAIL tie_cnt: i %0d d %0d want 1 1", gci[0], gcd[0]);
    end
  endtask
  task automatic test_fairness();
    int order[$];
    int iss_i, iss_d;
    do_reset();
    rnd_lat = 1;
    iss_i = 1; iss_d = 1;
    i_addr[0] = 32'h1_0000; i_read[0] = 1;
    d_addr[0] = 32'h2_0000; d_read[0] = 1;
    for (int n = 0; n < 200 && order.size() < 8; n++) begin
      tick();
      if (d_resp[0]) begin
        order.push_back(2);
        if (iss_d < 4) begin d_read[0] = 1; d_addr[0] = 32'h2_0000 + 32'(iss_d * 32); iss_d++; end
      end
      if (i_resp[0]) begin
        order.push_back(1);
        if (iss_i < 4) begin i_read[0] = 1; i_addr[0] = 32'h1_0000 + 32'(iss_i * 32); iss_i++; end
      end
    end
    checks++;
    if (order.size() != 8) begin
      errs++; $display("FAIL fair_count: got %0d want 8", order.size());
    end
    foreach (order[n]) begin
      checks++;
      if (order[n] != (n % 2 == 0 ? 2 : 1)) begin
        errs++; $display("FAIL fair_order[%0d]: got %0d want %0d", n, order[n], n % 2 == 0 ? 2 : 1);
      end
    end
    tick();
    tick();
    checks++;
    if (gci[0] !== 32'd4 || gcd[0] !== 32'd4) begin
      errs++; $display("FAIL fair_cnt: i %0d d %0d want 4 4", gci[0], gcd[0]);
    end
  endtask
  task automatic test_d_write_during_i();
    bit got;
    do_reset();
    rnd_lat = 0;
    lat[0] = 6;
    i_addr[0] = 32'h300; i_read[0] = 1;
    tick();
    tick();
    d_addr[0] = 32'h400; d_wdata[0] = {16{16'hDEAD}}; d_write[0] = 1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = i_resp[0];
      checks++;
      if (mem_write[0] !== 1'b0 || mem_addr[0] !== 32'h300) begin
        errs++; $display("FAIL dwr_held: wr %b addr %0h want 0 300", mem_write[0], mem_addr[0]);
      end
    end
    checks++;
    if (!got) begin errs++; $display("FAIL dwr_iresp: got timeout want i_resp"); end
    tick();
    checks++;
    if (mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0) begin
      errs++; $display("FAIL dwr_idle: rd %b wr %b want 0 0", mem_read[0], mem_write[0]);
    end
    tick();
    checks++;
    if (mem_write[0] !== 1'b1 || mem_read[0] !== 1'b0 || mem_addr[0] !== 32'h400 || mem_wdata[0] !== {16{16'hDEAD}}) begin
      errs++; $display("FAIL dwr_cmd: wr %b rd %b addr %0h wdata %0h want 1 0 400 %0h", mem_write[0], mem_read[0], mem_addr[0], mem_wdata[0], {16{16'hDEAD}});
    end
    got = d_resp[0];
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = d_resp[0];
    end
    checks++;
    if (!got || d_rdata[0] !== 256'h0) begin
      errs++; $display("FAIL dwr_resp: resp %b rdata %0h want 1 0", got, d_rdata[0]);
    end
  endtask
  task automatic test_prio();
    int order[$];
    int iss_d, last_d, i_start;
    bit prev;
    do_reset();
    rnd_lat = 0;
    lat[1] = 1;
    i_addr[1] = 32'h700; i_read[1] = 1;
    d_addr[1] = 32'h800; d_read[1] = 1;
    iss_d = 1; last_d = -100; i_start = -1; prev = 0;
    for (int n = 0; n < 60 && (order.size() == 0 || order[$] != 1); n++) begin
      tick();
      if (mem_read[1] && !prev && mem_addr[1] === 32'h700) i_start = n;
      prev = mem_read[1];
      if (d_resp[1]) begin
        order.push_back(2);
        last_d = n;
        if (iss_d < 3) begin d_read[1] = 1; d_addr[1] = 32'h800 + 32'(iss_d * 32); iss_d++; end
      end
      if (i_resp[1]) order.push_back(1);
    end
    checks++;
    if (order.size() != 4) begin
      errs++; $display("FAIL prio_count: got %0d want 4", order.size());
    end
    foreach (order[n]) begin
      checks++;
      if (order[n] != (n < 3 ? 2 : 1)) begin
        errs++; $display("FAIL prio_order[%0d]: got %0d want %0d", n, order[n], n < 3 ? 2 : 1);
      end
    end
    checks++;
    if (i_start - last_d != 2) begin
      errs++; $display("FAIL prio_i_gap: got %0d want 2", i_start - last_d);
    end
  endtask
  task automatic test_reset_mid();
    bit got;
    do_reset();
    rnd_lat = 0;
    lat[0] = 10;
    i_addr[0] = 32'h500; i_read[0] = 1;
    tick();
    tick();
    checks++;
    if (mem_read[0] !== 1'b1) begin errs++; $display("FAIL rmid_pre: rd %b want 1", mem_read[0]); end
    rst = 1;
    i_read[0] = 0;
    tick();
    checks++;
    if ({mem_read[0], mem_write[0], i_resp[0], d_resp[0]} !== 4'b0 || mem_addr[0] !== 32'h0 || mem_wdata[0] !== 256'h0) begin
      errs++; $display("FAIL rmid_out: ctl %b addr %0h wdata %0h want 0", {mem_read[0], mem_write[0], i_resp[0], d_resp[0]}, mem_addr[0], mem_wdata[0]);
    end
    checks++;
    if (gci[0] !== 32'h0 || gcd[0] !== 32'h0 || i_rdata[0] !== 256'h0 || d_rdata[0] !== 256'h0) begin
      errs++; $display("FAIL rmid_cnt: i %0d d %0d want 0 0", gci[0], gcd[0]);
    end
    rst = 0;
    lat[0] = 1;
    d_addr[0] = 32'h600; d_read[0] = 1;
    tick();
    checks++;
    if (mem_read[0] !== 1'b1 || mem_addr[0] !== 32'h600) begin
      errs++; $display("FAIL rmid_new_cmd: rd %b addr %0h want 1 600", mem_read[0], mem_addr[0]);
    end
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      tick();
      got = d_resp[0];
    end
    checks++;
    if (!got || d_rdata[0] !== dflt(32'h600)) begin
      errs++; $display("FAIL rmid_new_resp: resp %b rdata %0h want 1 %0h", got, d_rdata[0], dflt(32'h600));
    end
    tick();
    checks++;
    if (gci[0] !== 32'd0 || gcd[0] !== 32'd1) begin
      errs++; $display("FAIL rmid_new_cnt: i %0d d %0d want 0 1", gci[0], gcd[0]);
    end
  endtask
  task automatic test_random();
    int           own[2], last[2], ci[2], cd[2];
    bit           wr[2];
    logic [31:0]  a[2];
    logic [255:0] wd[2], exp_rd;
    bit           ei, ed, pi, pd, w;
    int           g;
    do_reset();
    rnd_lat = 1;
    for (int k = 0; k < 2; k++) begin own[k] = 0; last[k] = 1; ci[k] = 0; cd[k] = 0; wr[k] = 0; a[k] = 0; wd[k] = 0; end
    for (int n = 0; n < 300; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        ei = own[k] == 1 && mem_resp[k];
        ed = own[k] == 2 && mem_resp[k];
        exp_rd = store.exists({k[0], a[k]}) ? store[{k[0], a[k]}] : dflt(a[k]);
        checks++;
        if (mem_read[k] !== (own[k] != 0 && !wr[k]) || mem_write[k] !== (own[k] != 0 && wr[k])) begin
          errs++; $display("FAIL rnd_cmd[%0d] n%0d: rd %b wr %b want %b %b", k, n, mem_read[k], mem_write[k], own[k] != 0 && !wr[k], own[k] != 0 && wr[k]);
        end
        checks++;
        if (mem_addr[k] !== (own[k] != 0 ? a[k] : 32'h0) || mem_wdata[k] !== (own[k] != 0 ? wd[k] : 256'h0)) begin
          errs++; $display("FAIL rnd_mem[%0d] n%0d: addr %0h want %0h", k, n, mem_addr[k], own[k] != 0 ? a[k] : 32'h0);
        end
        checks++;
        if (i_resp[k] !== ei || d_resp[k] !== ed) begin
          errs++; $display("FAIL rnd_resp[%0d] n%0d: i %b d %b want %b %b", k, n, i_resp[k], d_resp[k], ei, ed);
        end
        checks++;
        if (i_rdata[k] !== (ei && !wr[k] ? exp_rd : 256'h0) || d_rdata[k] !== (ed && !wr[k] ? exp_rd : 256'h0)) begin
          errs++; $display("FAIL rnd_rdata[%0d] n%0d: i %0h d %0h", k, n, i_rdata[k], d_rdata[k]);
        end
        if (ed && wr[k]) store[{k[0], a[k]}] = wd[k];
        if (!i_read[k] && $urandom_range(0, 2) == 0) begin
          i_read[k] = 1; i_addr[k] = {21'h0, 6'($urandom_range(0, 63)), 5'h0}; i_wdata[k] = {8{$urandom}};
        end
        if (!(d_read[k] || d_write[k]) && $urandom_range(0, 2) == 0) begin
          w = 1'($urandom_range(0, 1));
          d_read[k] = !w; d_write[k] = w;
          d_addr[k] = {21'h0, 6'($urandom_range(0, 63)), 5'h0}; d_wdata[k] = {8{$urandom}};
        end
        if (own[k] != 0) begin
          if (mem_resp[k]) own[k] = 0;
        end else begin
          pi = i_read[k] || i_write[k];
          pd = d_read[k] || d_write[k];
          if (pi || pd) begin
            g = (pi && pd) ? ((k == 1 || last[k] == 1) ? 2 : 1) : (pd ? 2 : 1);
            own[k] = g; last[k] = g;
            a[k] = g == 2 ? d_addr[k] : i_addr[k];
            wd[k] = g == 2 ? d_wdata[k] : i_wdata[k];
            wr[k] = g == 2 ? d_write[k] : i_write[k];
            if (g == 2) cd[k]++; else ci[k]++;
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gci[k] !== 32'(ci[k]) || gcd[k] !== 32'(cd[k])) begin
        errs++; $display("FAIL rnd_cnt[%0d]: i %0d d %0d want %0d %0d", k, gci[k], gcd[k], ci[k], cd[k]);
      end
    end
  endtask
  initial begin
    rst = 1;
    errs = 0; checks = 0; rnd_lat = 0;
    for (int k = 0; k < 2; k++) begin
      age[k] = 0; lat[k] = 1; mem_resp[k] = 0; mem_rdata[k] = 0;
      i_read[k] = 0; i_write[k] = 0; d_read[k] = 0; d_write[k] = 0;
      i_addr[k] = 0; d_addr[k] = 0; i_wdata[k] = 0; d_wdata[k] = 0;
    end
    test_reset();
    test_i_read();
    test_tie();
    test_fairness();
    test_d_write_during_i();
    test_prio();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
